prince_enc_sequencer: RTL and testbench
=======================================

PRINCE_ENC_SEQUENCER -- requirements
Module: prince_enc_sequencer

Interface
REQ-001 Parameter SBOX_STAGES, default 2: pipeline depth of one masked S-box layer in the core; legal range 1..7.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low; 0 at a rising edge resets the block.
REQ-004 in_valid  input  1  plaintext shares and key present at the core inputs.
REQ-005 in_ready  output  1  sequencer can accept a new block.
REQ-006 out_valid  output  1  ciphertext shares valid at the core outputs.
REQ-007 out_ready  input  1  consumer takes the ciphertext.
REQ-008 rnd_valid  input  1  PRNG supplies fresh mask randomness this cycle.
REQ-009 rnd_req  output  1  sequencer consumes randomness this cycle if rnd_valid=1.
REQ-010 core_load  output  1  core state register loads whitened input.
REQ-011 core_en  output  1  global enable for every core state and pipeline register.
REQ-012 core_round  output  4  current round index 1..11.
REQ-013 core_sel  output  2  0 forward round, 1 middle layer, 2 backward round, 3 unused.
REQ-014 core_mid_inv  output  1  in middle layer, 0 = S-layer half, 1 = inverse S-layer half.
REQ-015 busy  output  1  encryption in progress (not IDLE).

Function
REQ-016 FSM states SHALL be IDLE, FWD, MID, BWD, DONE; one-hot or binary is implementer's choice.
REQ-017 in_ready SHALL be 1 only in IDLE; an input handshake is in_valid=1 and in_ready=1 at a rising edge.
REQ-018 core_load SHALL equal in_valid AND in_ready (combinational); handshake moves IDLE->FWD with core_round=1, stage=0.
REQ-019 In FWD, MID, BWD: rnd_req=1; core_en=rnd_valid; with rnd_valid=0 the stage counter, round, and state SHALL hold (stall), no other effect.
REQ-020 Stage counter: 4-bit, counts 0..SBOX_STAGES-1 in FWD/BWD, 0..2*SBOX_STAGES-1 in MID, advancing only when core_en=1.
REQ-021 FWD: on last stage with core_en, round increments; after round 5 completes, go MID with core_round=6, stage=0.
REQ-022 MID: core_sel=1; core_mid_inv=0 for stages 0..SBOX_STAGES-1, 1 for stages SBOX_STAGES..2*SBOX_STAGES-1; on final stage go BWD with core_round=7.
REQ-023 BWD: core_sel=2; round increments on last stage; after round 11 completes, go DONE.
REQ-024 core_sel=0 in FWD; core_sel, core_round, core_mid_inv SHALL be 0 in IDLE and DONE.
REQ-025 DONE: out_valid=1, held with core_en=0 until out_ready=1 at a rising edge, then IDLE; core outputs must not change while out_valid=1.
REQ-026 Latency with rnd_valid constantly 1: out_valid rises exactly 12*SBOX_STAGES+1 cycles after the input handshake edge (25 for default); each stall cycle adds one.
REQ-027 No new input accepted before the output handshake completes; the earliest next in_ready is the cycle after out handshake.
REQ-028 rnd_req, core_en, busy SHALL be 0 in IDLE; busy=1 in FWD, MID, BWD, DONE.
REQ-029 out_ready while not in DONE SHALL be ignored; in_valid outside IDLE SHALL be ignored.

Reset
REQ-030 reset=0 at a rising edge SHALL force IDLE, stage=0, round=0 from any state, including mid-round and during DONE, discarding the in-flight block.
REQ-031 Post-reset outputs: in_ready=1 (once reset=1), out_valid=0, busy=0, core_en=0, rnd_req=0, core_round=0, core_sel=0, core_mid_inv=0; core_load=0 while reset=0.
REQ-032 in_valid during the reset cycle SHALL not be accepted.

Verification
REQ-033 Default params, rnd_valid=1, single in_valid pulse, out_ready=1 -> core_round sequence 1,1,2,2..5,5,6x4,7,7..11,11; out_valid at cycle 25; IDLE at cycle 26.
REQ-034 rnd_valid=0 for 3 cycles in round 3 stage 1 -> round/stage frozen, core_en=0 during stall, out_valid at cycle 28.
REQ-035 MID with SBOX_STAGES=2 -> core_mid_inv 0,0,1,1, core_sel=1 for exactly 4 enabled cycles.
REQ-036 out_ready=0 for 5 cycles after DONE -> out_valid held 1, core_en=0, in_ready=0; handshake on 6th -> IDLE.
REQ-037 reset=0 in BWD round 9 -> next cycle IDLE, all outputs at REQ-031 values; subsequent encryption completes normally in 25 cycles.
REQ-038 SBOX_STAGES=1 and 3 -> latency 13 and 37 cycles respectively.

Source files
------------

// File: rtl/prince_enc_sequencer.sv
// prince_enc_sequencer: round/stage sequencer driving a masked, S-box-pipelined PRINCE encryption core
module prince_enc_sequencer #(
  parameter int SBOX_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic       rnd_valid,
  output logic       rnd_req,
  output logic       core_load,
  output logic       core_en,
  output logic [3:0] core_round,
  output logic [1:0] core_sel,
  output logic       core_mid_inv,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, FWD, MID, BWD, DONE} state_t;
  localparam logic [3:0] LAST     = 4'(SBOX_STAGES - 1);
  localparam logic [3:0] MID_LAST = 4'(2 * SBOX_STAGES - 1);
  localparam logic [3:0] HALF     = 4'(SBOX_STAGES);
  state_t     state;
  logic [3:0] stage;
  logic [3:0] round;
  logic       run;
  logic       last;
  // decode core controls and handshakes from the registered state; the core only advances when randomness is present
  always_comb begin
    run          = state == FWD || state == MID || state == BWD;
    last         = stage == (state == MID ? MID_LAST : LAST);
    in_ready     = state == IDLE && reset;
    core_load    = in_valid && in_ready;
    rnd_req      = run;
    core_en      = run && rnd_valid;
    out_valid    = state == DONE;
    busy         = state != IDLE;
    core_round   = round;
    core_sel     = state == MID ? 2'd1 : state == BWD ? 2'd2 : 2'd0;
    core_mid_inv = state == MID && stage >= HALF;
  end
  // walk forward rounds 1..5, the two-half middle layer as round 6, backward rounds 7..11, then hold the result
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      stage <= '0;
      round <= '0;
    end else if (core_load) begin
      state <= FWD;
      stage <= '0;
      round <= 4'd1;
    end else if (core_en) begin
      stage <= last ? '0 : stage + 4'd1;
      if (last) begin
        round <= (state == BWD && round == 4'd11) ? '0 : round + 4'd1;
        state <= state == FWD ? (round == 4'd5 ? MID : FWD) :
                 state == MID ? BWD : (round == 4'd11 ? DONE : BWD);
      end
    end else if (state == DONE && out_ready) begin
      state <= IDLE;
    end
endmodule

// File: tb/tb_prince_enc_sequencer.sv
// tb_prince_enc_sequencer: directed checks of the PRINCE sequencer with SBOX_STAGES = 2, 1 and 3 side by side
module tb_prince_enc_sequencer;
  logic       clk = 0;
  logic       reset = 0;
  logic       in_valid = 0;
  logic       out_ready = 1;
  logic       rnd_valid = 1;
  logic [2:0] in_ready, out_valid, rnd_req, core_load, core_en, core_mid_inv, busy;
  logic [3:0] core_round [3];
  logic [1:0] core_sel [3];
  int n_cmp = 0;
  int n_err = 0;
  int ov [3];
  int idl [3];
  int nsel;
  int exp_round [24] = '{1,1,2,2,3,3,4,4,5,5,6,6,6,6,7,7,8,8,9,9,10,10,11,11};
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    prince_enc_sequencer #(.SBOX_STAGES(g == 0 ? 2 : g == 1 ? 1 : 3)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready), .rnd_valid(rnd_valid),
      .rnd_req(rnd_req[g]), .core_load(core_load[g]), .core_en(core_en[g]),
      .core_round(core_round[g]), .core_sel(core_sel[g]),
      .core_mid_inv(core_mid_inv[g]), .busy(busy[g])
    );
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic idle_outputs(input string tag);
    check({tag, " in_ready"}, 32'(in_ready[0]), 1);
    check({tag, " out_valid"}, 32'(out_valid[0]), 0);
    check({tag, " busy"}, 32'(busy[0]), 0);
    check({tag, " core_en"}, 32'(core_en[0]), 0);
    check({tag, " rnd_req"}, 32'(rnd_req[0]), 0);
    check({tag, " round"}, 32'(core_round[0]), 0);
    check({tag, " sel"}, 32'(core_sel[0]), 0);
    check({tag, " mid_inv"}, 32'(core_mid_inv[0]), 0);
  endtask
  task automatic run(input int st, input int sl, input int hold, input int rst_at);
    ov = '{0, 0, 0};
    idl = '{0, 0, 0};
    nsel = 0;
    @(negedge clk);
    in_valid = 1;
    #1 check("core_load", 32'(core_load[0]), 1);
    @(posedge clk);
    #1 in_valid = 0;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      rnd_valid = !(cyc >= st && cyc < st + sl);
      out_ready = !(cyc >= 25 && cyc < 25 + hold);
      reset     = !(cyc == rst_at);
      in_valid  = hold > 0 && cyc == 26;
      #1;
      for (int i = 0; i < 3; i++) begin
        if (out_valid[i] && ov[i] == 0) ov[i] = cyc;
        if (ov[i] != 0 && in_ready[i] && idl[i] == 0) idl[i] = cyc;
      end
      if (core_sel[0] == 2'd1 && core_en[0]) nsel++;
      if (sl == 0 && hold == 0 && rst_at == 0 && cyc <= 24) begin
        check($sformatf("round c%0d", cyc), 32'(core_round[0]), 32'(exp_round[cyc-1]));
        check($sformatf("sel c%0d", cyc), 32'(core_sel[0]), cyc <= 10 ? 0 : cyc <= 14 ? 1 : 2);
        check($sformatf("mid_inv c%0d", cyc), 32'(core_mid_inv[0]), 32'(cyc == 13 || cyc == 14));
        check($sformatf("en c%0d", cyc), 32'(core_en[0]), 1);
      end
      if (sl > 0 && cyc >= st && cyc < st + sl) begin
        check($sformatf("stall en c%0d", cyc), 32'(core_en[0]), 0);
        check($sformatf("stall req c%0d", cyc), 32'(rnd_req[0]), 1);
        check($sformatf("stall round c%0d", cyc), 32'(core_round[0]), 3);
      end
      if (sl > 0 && cyc == st + sl) check("post-stall round", 32'(core_round[0]), 3);
      if (sl > 0 && cyc == st + sl + 1) check("post-stall next round", 32'(core_round[0]), 4);
      if (hold > 0 && cyc >= 25 && cyc <= 25 + hold) begin
        check($sformatf("hold out_valid c%0d", cyc), 32'(out_valid[0]), 1);
        check($sformatf("hold core_en c%0d", cyc), 32'(core_en[0]), 0);
        check($sformatf("hold in_ready c%0d", cyc), 32'(in_ready[0]), 0);
        check($sformatf("hold core_load c%0d", cyc), 32'(core_load[0]), 0);
      end
      if (rst_at > 0 && cyc == rst_at) check("pre-reset round", 32'(core_round[0]), 9);
      if (rst_at > 0 && cyc == rst_at + 1) idle_outputs("after reset");
      @(posedge clk);
      #1;
    end
    rnd_valid = 1;
    out_ready = 1;
    reset = 1;
    in_valid = 0;
  endtask
  initial begin
    reset = 0;
    in_valid = 1;
    repeat (2) @(posedge clk);
    #1;
    check("reset core_load", 32'(core_load[0]), 0);
    check("reset busy", 32'(busy[0]), 0);
    reset = 1;
    in_valid = 0;
    #1 idle_outputs("post-reset");
    run(0, 0, 0, 0);
    check("latency S2", 32'(ov[0]), 25);
    check("idle S2", 32'(idl[0]), 26);
    check("latency S1", 32'(ov[1]), 13);
    check("latency S3", 32'(ov[2]), 37);
    check("mid enabled cycles", 32'(nsel), 4);
    run(6, 3, 0, 0);
    check("stall latency", 32'(ov[0]), 28);
    run(0, 0, 5, 0);
    check("hold latency", 32'(ov[0]), 25);
    check("hold idle", 32'(idl[0]), 31);
    run(0, 0, 0, 19);
    check("reset run no output", 32'(ov[0]), 0);
    run(0, 0, 0, 0);
    check("latency after reset", 32'(ov[0]), 25);
    check("idle after reset", 32'(idl[0]), 26);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
